// File: rtl/generador_sinc_vga_if.sv
// Timing bundle between the VGA raster engine and the pixel/colour stage.
// The generator drives the master side; the consumer takes the slave side.
interface generador_sinc_vga_if #(
    parameter int CNT_W = 10
);
    logic             en;
    logic             pixel_tick;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_end;
    logic             frame_start;

    modport master (
        input  en,
        output pixel_tick, hsync, vsync, video_on,
        output pixel_x, pixel_y, line_end, frame_start
    );

    modport slave (
        output en,
        input  pixel_tick, hsync, vsync, video_on,
        input  pixel_x, pixel_y, line_end, frame_start
    );
endinterface

// File: rtl/generador_sinc_vga.sv
// Clocked VGA raster engine: pixel prescaler, h/v counters and
// registered sync, blanking, coordinates and line/frame strobes.
module generador_sinc_vga #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 10
) (
    input logic                clk,
    input logic                reset_n,
    generador_sinc_vga_if.master vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int P_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [P_W-1:0]   pre_t;

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_BEG = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_BEG = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam pre_t P_LAST = pre_t'(CLK_DIV - 1);

    pre_t p_q, p_d;
    cnt_t h_q, h_d;
    cnt_t v_q, v_d;
    logic tick;
    logic fs_d;
    logic pt_d, hs_d, vs_d, vo_d, le_d;
    logic pt_q, hs_q, vs_q, vo_q, le_q, fs_q;

    // Next prescaler and counter values; en low parks everything at origin.
    always_comb begin
        tick = (p_q == P_LAST);
        p_d  = '0;
        h_d  = '0;
        v_d  = '0;
        fs_d = 1'b0;
        if (vif.en) begin
            p_d = tick ? '0 : p_q + 1'b1;
            h_d = h_q;
            v_d = v_q;
            if (tick) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d  = '0;
                        fs_d = 1'b1;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end
    end

    // Decode outputs from the post-edge counter values so they align with x/y.
    always_comb begin
        pt_d = vif.en && (p_d == P_LAST);
        le_d = pt_d && (h_d == H_LAST);
        vo_d = vif.en && (h_d < H_VIS) && (v_d < V_VIS);
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        if (vif.en && (h_d >= HS_BEG) && (h_d <= HS_END)) begin
            hs_d = HS_POL;
        end
        if (vif.en && (v_d >= VS_BEG) && (v_d <= VS_END)) begin
            vs_d = VS_POL;
        end
    end

    // State and output registers; reset drops straight to idle values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q  <= '0;
            h_q  <= '0;
            v_q  <= '0;
            pt_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            vo_q <= 1'b0;
            le_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            p_q  <= p_d;
            h_q  <= h_d;
            v_q  <= v_d;
            pt_q <= pt_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            vo_q <= vo_d;
            le_q <= le_d;
            fs_q <= fs_d;
        end
    end

    assign vif.pixel_tick  = pt_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.video_on    = vo_q;
    assign vif.pixel_x     = h_q;
    assign vif.pixel_y     = v_q;
    assign vif.line_end    = le_q;
    assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_generador_sinc_vga.sv
// Directed bench for generador_sinc_vga: default 640x480, 800x600
// active-high at one clock per pixel, and a tiny raster for frame timing.
module tb_generador_sinc_vga;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    generador_sinc_vga_if #(.CNT_W(10)) if_a ();
    generador_sinc_vga_if #(.CNT_W(11)) if_b ();
    generador_sinc_vga_if #(.CNT_W(5))  if_s ();

    generador_sinc_vga dut_a (
        .clk(clk), .reset_n(reset_n), .vif(if_a)
    );

    generador_sinc_vga #(
        .CLK_DIV(1),
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .vif(if_b)
    );

    generador_sinc_vga #(
        .CLK_DIV(3),
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(5)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .vif(if_s)
    );

    typedef struct {
        int x;
        int y;
        bit hs, vs, vo, pt, le, fs;
    } obs_t;

    typedef struct {
        int   ph;
        int   k;
        bit   en;
        obs_t e;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cur_k = 0;

    function automatic obs_t mk(int x, int y, bit hs, bit vs,
                                bit vo, bit pt, bit le, bit fs);
        obs_t o;
        o.x = x; o.y = y; o.hs = hs; o.vs = vs;
        o.vo = vo; o.pt = pt; o.le = le; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t v(int ph, int k, int x, int y, bit hs, bit vs,
                               bit vo, bit pt, bit le, bit fs);
        vec_t r;
        r.ph = ph; r.k = k; r.en = 1'b1;
        r.e = mk(x, y, hs, vs, vo, pt, le, fs);
        return r;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d hs=%0b vs=%0b vo=%0b pt=%0b le=%0b fs=%0b",
                         o.x, o.y, o.hs, o.vs, o.vo, o.pt, o.le, o.fs);
    endfunction

    function automatic obs_t snap(int ph);
        obs_t o;
        case (ph)
            0: o = mk(int'(if_a.pixel_x), int'(if_a.pixel_y), if_a.hsync,
                      if_a.vsync, if_a.video_on, if_a.pixel_tick,
                      if_a.line_end, if_a.frame_start);
            1: o = mk(int'(if_b.pixel_x), int'(if_b.pixel_y), if_b.hsync,
                      if_b.vsync, if_b.video_on, if_b.pixel_tick,
                      if_b.line_end, if_b.frame_start);
            default: o = mk(int'(if_s.pixel_x), int'(if_s.pixel_y), if_s.hsync,
                            if_s.vsync, if_s.video_on, if_s.pixel_tick,
                            if_s.line_end, if_s.frame_start);
        endcase
        return o;
    endfunction

    task automatic chk(string nm, obs_t a, obs_t e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got {%s} want {%s}", nm, fmt(a), fmt(e));
        end
    endtask

    task automatic chk_cnt(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic set_en(int ph, bit val);
        case (ph)
            0: if_a.en = val;
            1: if_b.en = val;
            default: if_s.en = val;
        endcase
    endtask

    task automatic adv(int k);
        repeat (k - cur_k) @(posedge clk);
        #1;
        cur_k = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_a", snap(0), mk(0, 0, 1, 1, 0, 0, 0, 0));
        chk("rst_b", snap(1), mk(0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_s", snap(2), mk(0, 0, 1, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        cur_k = 0;
    endtask

    task automatic run_phase(int ph);
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].ph == ph) begin
                set_en(ph, tbl[i].en);
                adv(tbl[i].k);
                chk($sformatf("p%0d_k%0d", ph, tbl[i].k), snap(ph), tbl[i].e);
            end
        end
    endtask

    initial begin
        int c0, c1, c2, c3, c4;

        if_a.en = 1'b1;
        if_b.en = 1'b1;
        if_s.en = 1'b1;

        // default 640x480, two clocks per pixel, active-low syncs
        tbl.push_back(v(0,    0,   0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0,    1,   0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0,    2,   1, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0,    3,   1, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 1279, 639, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 1280, 640, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1311, 655, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 1312, 656, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1503, 751, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 1504, 752, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1598, 799, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1599, 799, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 1600,   0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1601,   0, 1, 1, 1, 1, 1, 0, 0));
        // 800x600, one clock per pixel, active-high syncs
        tbl.push_back(v(1,    0,    0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1,    1,    1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1,  799,  799, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1,  800,  800, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1,  839,  839, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1,  840,  840, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(1,  967,  967, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(1,  968,  968, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 1055, 1055, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(1, 1056,    0, 1, 0, 0, 1, 1, 0, 0));
        // 16x11 raster, three clocks per pixel, hs low / vs high
        tbl.push_back(v(2,   0,  0,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(2,   1,  0,  0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2,   2,  0,  0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(2,   3,  1,  0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2,  23,  7,  0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(2,  24,  8,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(2,  30, 10,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(2,  38, 12,  0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(2,  39, 13,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(2,  47, 15,  0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(2,  48,  0,  1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 335, 15,  6, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(2, 336,  0,  7, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(2, 431, 15,  8, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(2, 432,  0,  9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(2, 527, 15, 10, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(2, 528,  0,  0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(v(2, 529,  0,  0, 1, 0, 1, 0, 0, 0));

        run_phase(0);
        // any 1600-clock window holds exactly one default line
        c0 = 0; c1 = 0;
        for (int i = 0; i < 1600; i++) begin
            @(posedge clk); #1;
            if (!if_a.hsync) c0++;
            if (if_a.line_end) c1++;
        end
        chk_cnt("a_hsync_low_clks", c0, 192);
        chk_cnt("a_line_end_per_line", c1, 1);

        run_phase(1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 1056; i++) begin
            @(posedge clk); #1;
            if (if_b.hsync) c0++;
            if (!if_b.pixel_tick) c1++;
        end
        chk_cnt("b_hsync_high_clks", c0, 128);
        chk_cnt("b_tick_low_clks", c1, 0);

        run_phase(2);
        // one full small frame is 16*11*3 = 528 clocks
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        for (int i = 0; i < 528; i++) begin
            @(posedge clk); #1;
            if (if_s.frame_start) c0++;
            if (if_s.vsync) c1++;
            if (if_s.video_on) c2++;
            if (if_s.line_end) c3++;
            if (if_s.video_on && (if_s.pixel_x >= 5'd8 || if_s.pixel_y >= 5'd6))
                c4++;
        end
        cur_k += 528;
        chk_cnt("s_frame_start_per_frame", c0, 1);
        chk_cnt("s_vsync_high_clks", c1, 96);
        chk_cnt("s_video_on_clks", c2, 144);
        chk_cnt("s_line_end_per_frame", c3, 11);
        chk_cnt("s_video_on_outside", c4, 0);

        // drop en mid-frame at (5,3), hold 10 clocks, then restart
        adv(1216);
        chk("s_pre_drop", snap(2), mk(5, 3, 1, 0, 1, 0, 0, 0));
        if_s.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("s_en_low_%0d", i), snap(2), mk(0, 0, 1, 0, 0, 0, 0, 0));
        end
        if_s.en = 1'b1;
        @(posedge clk); #1;
        chk("s_restart_1", snap(2), mk(0, 0, 1, 0, 1, 0, 0, 0));
        @(posedge clk); #1;
        chk("s_restart_2", snap(2), mk(0, 0, 1, 0, 1, 1, 0, 0));
        @(posedge clk); #1;
        chk("s_restart_3", snap(2), mk(1, 0, 1, 0, 1, 0, 0, 0));

        // asynchronous reset in the middle of the hsync pulse
        do_reset();
        adv(1312);
        chk("a_pre_async", snap(0), mk(656, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("a_async_rst", snap(0), mk(0, 0, 1, 1, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cur_k = 0;
        adv(1);
        chk("a_after_async_k1", snap(0), mk(0, 0, 1, 1, 1, 1, 0, 0));
        adv(2);
        chk("a_after_async_k2", snap(0), mk(1, 0, 1, 1, 1, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/generador_sinc_vga.md
Name: generador_sinc_vga

Overview:
Parametrised VGA timing generator. It replaces the combinational, vertical-only sync decode with a complete clocked raster engine. It holds a pixel-clock prescaler plus horizontal and vertical counters, and produces registered hsync, vsync, video_on, pixel coordinates and frame/line strobes. It sits between the system clock and the pixel/colour generator of the video path.

Parameters:
CLK_DIV, 2, system clocks per pixel (≥1); 2 gives 25 MHz from 50 MHz
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CNT_W, 10, width of pixel_x/pixel_y; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  generator enable; low = blank and hold at origin
pixel_tick  output  1  one-clk pulse marking each pixel period
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
video_on  output  1  high while (pixel_x, pixel_y) is inside the visible area
pixel_x  output  CNT_W  current horizontal count, 0..H_TOTAL-1
pixel_y  output  CNT_W  current vertical count, 0..V_TOTAL-1
line_end  output  1  one-clk pulse on the tick where pixel_x = H_TOTAL-1
frame_start  output  1  one-clk pulse on the tick where the counters move to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800); V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
- Reset (reset_n low, asynchronous): prescaler = 0, h = v = 0, pixel_x = pixel_y = 0, hsync = ~HS_POL, vsync = ~VS_POL, video_on = 0, pixel_tick = line_end = frame_start = 0. All outputs are registered and hold these values until the first clk edge after release.
- Prescaler: counts 0..CLK_DIV-1 and wraps. pixel_tick is high for one clk when the prescaler equals CLK_DIV-1. With CLK_DIV = 1, pixel_tick is permanently high while en = 1. After reset release the first tick occurs on the CLK_DIV-th edge.
- Horizontal counter: increments on pixel_tick. At H_TOTAL-1 it wraps to 0, and on that same edge the vertical counter increments.
- Vertical counter: wraps to 0 at V_TOTAL-1. Both wraps occurring on the same tick is the frame wrap; frame_start asserts on that edge.
- Sync decode: hsync is active when h lies in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751 with the defaults. vsync is active when v lies in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491. Both ends of each range are inclusive, and hsync/vsync are inactive outside these ranges.
- video_on = (h < H_VISIBLE) AND (v < V_VISIBLE).
- Output timing: every clk edge loads hsync, vsync, video_on, pixel_x and pixel_y from the decode of the counter values valid after that edge. The outputs are therefore always mutually consistent and glitch-free, with zero skew to pixel_x/pixel_y.
- line_end and frame_start are registered with the same alignment.
- en low (synchronous): the prescaler and counters are cleared to 0 and all strobes are 0. hsync and vsync are held inactive and video_on is 0. When en returns high, counting restarts from (0,0) and the first tick occurs after CLK_DIV edges; frame_start is not pulsed for this restart.
- Reset or en drop mid-frame abandons the frame immediately, with no completion of the current line.
- Comparisons use CNT_W-bit unsigned arithmetic; no intermediate overflow is permitted given the CNT_W constraint.

Test Plan:
1. Reset: hold reset_n low for 5 clks, then release → all outputs at their reset values while low; pixel_x advances to 1 on edge 2 after release (defaults); video_on = 1 from edge 1.
2. Horizontal timing, defaults: hsync low exactly for pixel_x 656..751 (96 ticks = 192 clks); line period 1600 clks; line_end once per line at x = 799.
3. Vertical timing, defaults: vsync low only for pixel_y 490..491; frame = 525 × 800 ticks = 840000 clks; frame_start once per frame; video_on is never high for y ≥ 480 or x ≥ 640.
4. Parameter sweep: CLK_DIV = 1, HS_POL = VS_POL = 1, 800×600 timing (40/128/88, 1/4/23) → pixel_tick constantly high; hsync high only for x 840..967; vsync high only for y 601..604.
5. en dropped at (x = 300, y = 200) for 10 clks → outputs blank and counters at 0 within 1 clk; after en rises, counting restarts at (0,0) with no frame_start pulse.
6. reset_n asserted asynchronously between clk edges mid-line → outputs take their reset values immediately, without waiting for clk; normal timing resumes after release as in scenario 1.
